uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the UART transmitter in the same serial block.
- Recovers 8N1/8E1/8O1/8x2 frames from the serial line using an oversampled clock and mid-bit sampling.
- Delivers each byte over a valid/ready interface with per-byte parity and framing status, plus an overrun pulse.
- Configuration encoding matches the transmitter:
  - cfg_parity_type_i: 0 = even, 1 = odd.
  - cfg_stop_bits_i: 1 = two stop bits.

Parameters:
OVERSAMPLE, 8, clk_i cycles per bit period; even, >= 4; bit counter width is $clog2(OVERSAMPLE).

Ports:
clk_i  input  1  clock, OVERSAMPLE x bit rate
arst_ni  input  1  asynchronous active-low reset
cfg_parity_en_i  input  1  1 = frame carries a parity bit
cfg_parity_type_i  input  1  0 = even, 1 = odd
cfg_stop_bits_i  input  1  0 = one stop bit, 1 = two stop bits
rx_i  input  1  serial line, idle high, asynchronous to clk_i
rx_data_o  output  8  received byte, LSB first on line
rx_data_valid_o  output  1  rx_data_o and error flags valid
rx_data_ready_i  input  1  consumer accepts byte
rx_parity_err_o  output  1  parity mismatch for current byte (qualified by valid)
rx_frame_err_o  output  1  stop bit sampled low for current byte (qualified by valid)
rx_overrun_o  output  1  one-cycle pulse: completed frame dropped
rx_busy_o  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk_i, arst_ni).
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Synchronizer flops 1.
- Synchronizer:
  - rx_i passes through 2 flops to give rx_sync, so rx_sync lags rx_i by 2 cycles.
  - Only rx_sync is used internally.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE.
- T0 is the first edge in IDLE where rx_sync = 0. Sample points:
  - Start bit: T0 + OVERSAMPLE/2.
  - Each later bit: +OVERSAMPLE after the previous sample.
- IDLE:
  - On rx_sync = 0, go to START and clear the bit counter.
- START:
  - At the start sample point, if rx_sync = 1, treat as a false start and return to IDLE (no output).
  - Otherwise latch the cfg_* inputs for the frame and go to DATA.
  - cfg changes mid-frame have no effect.
- DATA:
  - 8 samples, shifted LSB first.
  - Then go to PARITY if parity is enabled, else STOP1.
- PARITY:
  - Expected parity = ^data ^ parity_type.
  - Mismatch sets the internal parity error.
- STOP1:
  - rx_sync = 0 sets the internal framing error.
  - Go to STOP2 if two stop bits are configured, else end the frame.
- STOP2:
  - Same check as STOP1, OR-ed into the framing error; then end the frame.
- End of frame, on the cycle after the last stop sample:
  - If rx_data_valid_o = 0: load rx_data_o and both error flags, and assert valid.
  - If rx_data_valid_o = 1 and rx_data_ready_i = 0: discard the new frame, keep the old byte, pulse rx_overrun_o for 1 cycle.
  - If valid and ready are both high in that cycle: the old byte is accepted and the new byte loads (no overrun).
- Next state after end of frame:
  - Framing error set: go to WAIT_IDLE, which stays until rx_sync = 1, then goes to IDLE. This prevents a break or low line from being read as a start bit.
  - Otherwise: IDLE, re-armed immediately.
- Handshake:
  - rx_data_valid_o stays high, with data and flags stable, until a cycle with rx_data_ready_i = 1.
  - It deasserts on the next cycle.
- Reset mid-frame: immediate return to IDLE, partial byte lost, outputs cleared.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN:
- When defined, every bit sample (start, data, parity, stop) is the 2-of-3 majority of rx_sync at sample point −1, 0 and +1.
- Sample timing is unchanged; the decision is registered at sample point +1.
- All later events slip by 1 cycle: valid at T0+78 for the case in test 1.
- When undefined, a single sample is taken at the sample point.

Test Plan:
1. OVERSAMPLE=8, no parity, 1 stop, frame 0xA5, ready=1 -> valid at T0+77 (single sample); rx_data_o=0xA5; both error flags 0.
2. Even parity, byte 0x07, correct parity bit 1 -> data 0x07, parity_err=0. Same frame with parity bit 0 -> parity_err=1, data 0x07.
3. Two stop bits, byte 0x3C, second stop bit driven low -> frame_err=1. FSM stays in WAIT_IDLE until rx_i returns high; the next frame, 0x81, is received correctly.
4. rx_i low pulse of 3 cycles, then high -> no valid, back in IDLE, rx_busy_o falls after the start sample.
5. ready=0: frames 0x11 then 0x22 -> rx_data_o holds 0x11, one overrun pulse at the end of 0x22. Raising ready then drops valid the following cycle.
6. arst_ni asserted after DATA bit 4 of frame 0x55 -> outputs 0, IDLE. The next frame, 0x99, is received intact.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: two-flop synchronizer, oversampled mid-bit sampling, and a
// valid/ready byte interface with per-byte parity/framing status and an
// overrun pulse. Frame formats 8N1, 8E1, 8O1 and 8x2.
//
// Optional build macro: UART_RX_MAJORITY_VOTE_EN
//   defined   -> each bit is the 2-of-3 vote of rx_sync at sample point -1/0/+1,
//                decided at sample point +1 (all later events one cycle later)
//   undefined -> each bit is the single rx_sync value at the sample point
//
// Ports:
//   clk_i              clock, OVERSAMPLE x bit rate
//   arst_ni            asynchronous active-low reset
//   cfg_parity_en_i    1 = frame carries a parity bit
//   cfg_parity_type_i  0 = even, 1 = odd
//   cfg_stop_bits_i    0 = one stop bit, 1 = two stop bits
//   rx_i               serial line, idle high, asynchronous to clk_i
//   rx_data_o          received byte (LSB first on the line)
//   rx_data_valid_o    rx_data_o and error flags valid
//   rx_data_ready_i    consumer accepts byte
//   rx_parity_err_o    parity mismatch for the presented byte
//   rx_frame_err_o     a stop bit was sampled low for the presented byte
//   rx_overrun_o       one-cycle pulse: a completed frame was dropped
//   rx_busy_o          high in any state other than IDLE
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic       clk_i,
    input  logic       arst_ni,
    input  logic       cfg_parity_en_i,
    input  logic       cfg_parity_type_i,
    input  logic       cfg_stop_bits_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_data_valid_o,
    input  logic       rx_data_ready_i,
    output logic       rx_parity_err_o,
    output logic       rx_frame_err_o,
    output logic       rx_overrun_o,
    output logic       rx_busy_o
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned HALF  = OVERSAMPLE / 2;
    // Counter is cleared on the T0 edge and on every sample edge, so the
    // start sample fires at count HALF-1 and later ones at OVERSAMPLE-1.
    // The vote variant decides one cycle later.
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int unsigned FIRST_TICK = HALF;
`else
    localparam int unsigned FIRST_TICK = HALF - 1;
`endif
    localparam int unsigned LAST_TICK = OVERSAMPLE - 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        WAIT_IDLE
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync_q;
    logic             rx_sync;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_en_q, par_en_d;
    logic             par_type_q, par_type_d;
    logic             stop2_q, stop2_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             done_q, done_d;
    logic             tick;
    logic             sample;
    logic             ferr_next;

    logic [7:0]       data_d;
    logic             valid_d;
    logic             perr_out_d;
    logic             ferr_out_d;
    logic             overrun_d;
    logic             busy_d;

    // Two-flop synchronizer, idles high
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_sync = sync_q[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
    // rx_sync history: [0] = value at the previous edge, [1] = two edges back
    logic [1:0] hist_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_sync};
        end
    end

    assign sample = (rx_sync & hist_q[0]) | (rx_sync & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample = rx_sync;
`endif

    assign tick = (state_q == START) ? (cnt_q == CNT_W'(FIRST_TICK))
                                     : (cnt_q == CNT_W'(LAST_TICK));

    // Next-state, datapath and output next values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        stop2_d    = stop2_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        done_d     = 1'b0;
        ferr_next  = ferr_q | ~sample;

        data_d     = rx_data_o;
        valid_d    = rx_data_valid_o & ~rx_data_ready_i;
        perr_out_d = rx_parity_err_o;
        ferr_out_d = rx_frame_err_o;
        overrun_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_sync) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    cnt_d = '0;
                    if (sample) begin
                        state_d = IDLE;
                    end else begin
                        par_en_d   = cfg_parity_en_i;
                        par_type_d = cfg_parity_type_i;
                        stop2_d    = cfg_stop_bits_i;
                        bit_idx_d  = '0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d     = '0;
                    shift_d   = {sample, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = par_en_q ? PARITY : STOP1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    cnt_d   = '0;
                    perr_d  = sample ^ (^shift_q) ^ par_type_q;
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (tick) begin
                    cnt_d  = '0;
                    ferr_d = ferr_next;
                    if (stop2_q) begin
                        state_d = STOP2;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ferr_next ? WAIT_IDLE : IDLE;
                    end
                end
            end
            STOP2: begin
                if (tick) begin
                    cnt_d   = '0;
                    ferr_d  = ferr_next;
                    done_d  = 1'b1;
                    state_d = ferr_next ? WAIT_IDLE : IDLE;
                end
            end
            WAIT_IDLE: begin
                // Hold off re-arming until the line is back high
                cnt_d = '0;
                if (rx_sync) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Frame delivery: load when the holding register is free or being
        // drained this cycle, otherwise drop the new frame and flag overrun.
        if (done_q) begin
            if (!rx_data_valid_o || rx_data_ready_i) begin
                data_d     = shift_q;
                perr_out_d = perr_q;
                ferr_out_d = ferr_q;
                valid_d    = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            par_en_q        <= 1'b0;
            par_type_q      <= 1'b0;
            stop2_q         <= 1'b0;
            perr_q          <= 1'b0;
            ferr_q          <= 1'b0;
            done_q          <= 1'b0;
            rx_data_o       <= '0;
            rx_data_valid_o <= 1'b0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
            rx_overrun_o    <= 1'b0;
            rx_busy_o       <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            par_en_q        <= par_en_d;
            par_type_q      <= par_type_d;
            stop2_q         <= stop2_d;
            perr_q          <= perr_d;
            ferr_q          <= ferr_d;
            done_q          <= done_d;
            rx_data_o       <= data_d;
            rx_data_valid_o <= valid_d;
            rx_parity_err_o <= perr_out_d;
            rx_frame_err_o  <= ferr_out_d;
            rx_overrun_o    <= overrun_d;
            rx_busy_o       <= busy_d;
        end
    end

endmodule
